// File: rtl/pll_reconfig_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_pkg
// Purpose  : Shared constants and types for the PLL reconfiguration
//            sequencer. This package holds the reconfiguration controller
//            register map, the counter field widths and the FSM state type.
// Revision : 1.0 - initial release
// ============================================================================
package pll_reconfig_pkg;

    // Reconfiguration controller register map (word addresses)
    localparam logic [5:0] c_ADDR_MODE   = 6'h00;
    localparam logic [5:0] c_ADDR_STATUS = 6'h01;
    localparam logic [5:0] c_ADDR_START  = 6'h02;
    localparam logic [5:0] c_ADDR_N      = 6'h03;
    localparam logic [5:0] c_ADDR_M      = 6'h04;
    localparam logic [5:0] c_ADDR_C      = 6'h05;

    // Counter value and C-counter selector field widths
    localparam int c_CNT_W  = 18;
    localparam int c_CSEL_W = 5;

    // S_RD_M is only reachable when read-back verification is compiled in
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_WR_MODE   = 3'd1,
        S_WR_N      = 3'd2,
        S_WR_M      = 3'd3,
        S_RD_M      = 3'd4,
        S_WR_C      = 3'd5,
        S_WR_START  = 3'd6,
        S_WAIT_LOCK = 3'd7
    } state_e;

endpackage
`default_nettype wire

// File: rtl/pll_reconfig_avmm_master.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_avmm_master
// Purpose  : Single-transaction Avalon-MM master. A command pulse loads one
//            read or write. The master then holds it on registered outputs
//            until waitrequest is low. A completion strobe is raised on that
//            same cycle, so a new command may be loaded on the cycle the
//            previous one completes, which gives back-to-back transfers.
// Ports    : clk_i/rst_i           clock, asynchronous active-high reset
//            cmd_wr_i/cmd_rd_i     load a write / read command
//            cmd_addr_i/cmd_wdata_i command address and write data
//            xfer_done_o           transfer accepted by the slave this cycle
//            av_*                  Avalon-MM master signals
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_avmm_master #(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              cmd_wr_i,
    input  logic              cmd_rd_i,
    input  logic [ADDR_W-1:0] cmd_addr_i,
    input  logic [DATA_W-1:0] cmd_wdata_i,
    output logic              xfer_done_o,
    output logic [ADDR_W-1:0] av_address_o,
    output logic              av_read_o,
    output logic              av_write_o,
    output logic [DATA_W-1:0] av_writedata_o,
    input  logic              av_waitrequest_i
);

    logic              write_q;
    logic              read_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;

    assign xfer_done_o = (write_q | read_q) & ~av_waitrequest_i;

    // A new command takes priority over clearing the strobes. This lets the
    // next transfer follow a completing one with no idle cycle between them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (cmd_wr_i || cmd_rd_i) begin
            write_q <= cmd_wr_i;
            read_q  <= cmd_rd_i;
            addr_q  <= cmd_addr_i;
            wdata_q <= cmd_wdata_i;
        end else if (xfer_done_o) begin
            write_q <= 1'b0;
            read_q  <= 1'b0;
        end
    end

    assign av_address_o   = addr_q;
    assign av_read_o      = read_q;
    assign av_write_o     = write_q;
    assign av_writedata_o = wdata_q;

endmodule
`default_nettype wire

// File: rtl/pll_reconfig_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : pll_reconfig_sequencer
// Purpose  : Accepts one PLL frequency-change request (N, M, one C counter).
//            It writes the request into the reconfiguration controller as
//            MODE, N, M, C, START, then waits for the PLL to relock, with a
//            timeout. Completion is reported with done; error is valid
//            alongside done.
// Ports    : clk_clk, reset_reset (asynchronous, active high)
//            req_*        request handshake and fields
//            mgmt_*       Avalon-MM master to the reconfig controller
//            pll_locked   raw lock indication, synchronised internally
//            busy/done/error status to the clock-control logic
// Options  : PLL_RECONFIG_SEQUENCER_READBACK_EN adds an M-counter read-back
//            check between the M and C writes.
// Revision : 1.0 - initial release
// ============================================================================
module pll_reconfig_sequencer #(
    parameter int LOCK_TIMEOUT = 65535,
    parameter int LOCK_BLANK   = 8,
    parameter int ADDR_W       = 6,
    parameter int DATA_W       = 32
) (
    input  logic              clk_clk,
    input  logic              reset_reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [17:0]       req_n,
    input  logic [17:0]       req_m,
    input  logic [17:0]       req_c,
    input  logic [4:0]        req_c_sel,
    output logic [ADDR_W-1:0] mgmt_address,
    output logic              mgmt_read,
    output logic              mgmt_write,
    output logic [DATA_W-1:0] mgmt_writedata,
    input  logic [DATA_W-1:0] mgmt_readdata,
    input  logic              mgmt_waitrequest,
    input  logic              pll_locked,
    output logic              busy,
    output logic              done,
    output logic              error
);
    import pll_reconfig_pkg::*;

    localparam int              TMO_W      = $clog2(LOCK_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] c_TMO_LAST = TMO_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMO_W-1:0] c_BLANK    = TMO_W'(LOCK_BLANK);

    state_e                state_q, state_d;
    logic [TMO_W-1:0]      cnt_q, cnt_d;
    logic                  done_q, done_d;
    logic                  error_q, error_d;
    logic [c_CNT_W-1:0]    n_q, m_q, c_q;
    logic [c_CSEL_W-1:0]   csel_q;
    logic                  lk_meta_q, lk_sync_q;

    logic                  w_accept;
    logic                  w_cmd_wr;
    logic                  w_cmd_rd;
    logic [ADDR_W-1:0]     w_cmd_addr;
    logic [DATA_W-1:0]     w_cmd_wdata;
    logic                  w_xfer_done;
    logic                  w_unused_rdata;

    // Only the low M-counter bits are ever compared
    assign w_unused_rdata = ^mgmt_readdata;

    // ------------------------------------------------------------------------
    // State, counter, captured request and lock synchroniser
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
            n_q       <= '0;
            m_q       <= '0;
            c_q       <= '0;
            csel_q    <= '0;
            lk_meta_q <= 1'b0;
            lk_sync_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            error_q   <= error_d;
            lk_meta_q <= pll_locked;
            lk_sync_q <= lk_meta_q;
            if (w_accept) begin
                n_q    <= req_n;
                m_q    <= req_m;
                c_q    <= req_c;
                csel_q <= req_c_sel;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next state. Each transfer state issues the command for its successor
    // on the cycle its own transfer completes.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        error_d     = error_q;
        w_accept    = 1'b0;
        w_cmd_wr    = 1'b0;
        w_cmd_rd    = 1'b0;
        w_cmd_addr  = '0;
        w_cmd_wdata = '0;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    w_accept   = 1'b1;
                    error_d    = 1'b0;
                    state_d    = S_WR_MODE;
                    w_cmd_wr   = 1'b1;
                    w_cmd_addr = ADDR_W'(c_ADDR_MODE);  // 0 selects waitrequest mode
                end
            end
            S_WR_MODE: begin
                if (w_xfer_done) begin
                    state_d                   = S_WR_N;
                    w_cmd_wr                  = 1'b1;
                    w_cmd_addr                = ADDR_W'(c_ADDR_N);
                    w_cmd_wdata[c_CNT_W-1:0]  = n_q;
                end
            end
            S_WR_N: begin
                if (w_xfer_done) begin
                    state_d                   = S_WR_M;
                    w_cmd_wr                  = 1'b1;
                    w_cmd_addr                = ADDR_W'(c_ADDR_M);
                    w_cmd_wdata[c_CNT_W-1:0]  = m_q;
                end
            end
            S_WR_M: begin
                if (w_xfer_done) begin
`ifdef PLL_RECONFIG_SEQUENCER_READBACK_EN
                    state_d    = S_RD_M;
                    w_cmd_rd   = 1'b1;
                    w_cmd_addr = ADDR_W'(c_ADDR_M);
`else
                    state_d    = S_WR_C;
                    w_cmd_wr   = 1'b1;
                    w_cmd_addr = ADDR_W'(c_ADDR_C);
                    w_cmd_wdata[c_CNT_W+c_CSEL_W-1:0] = {csel_q, c_q};
`endif
                end
            end
`ifdef PLL_RECONFIG_SEQUENCER_READBACK_EN
            S_RD_M: begin
                // readdata is valid on the cycle the read completes
                if (w_xfer_done) begin
                    if (mgmt_readdata[c_CNT_W-1:0] == m_q) begin
                        state_d    = S_WR_C;
                        w_cmd_wr   = 1'b1;
                        w_cmd_addr = ADDR_W'(c_ADDR_C);
                        w_cmd_wdata[c_CNT_W+c_CSEL_W-1:0] = {csel_q, c_q};
                    end else begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            S_WR_C: begin
                if (w_xfer_done) begin
                    state_d    = S_WR_START;
                    w_cmd_wr   = 1'b1;
                    w_cmd_addr = ADDR_W'(c_ADDR_START);
                end
            end
            S_WR_START: begin
                if (w_xfer_done) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end
            end
            S_WAIT_LOCK: begin
                // Lock is ignored during the blanking window because the PLL
                // may still report the old lock right after the start write.
                if ((cnt_q >= c_BLANK) && lk_sync_q) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b0;
                end else if (cnt_q == c_TMO_LAST) begin
                    // Done lands exactly LOCK_TIMEOUT cycles after entry.
                    // The counter stops here, so it never wraps.
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                    error_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    pll_reconfig_avmm_master #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_master (
        .clk_i            (clk_clk),
        .rst_i            (reset_reset),
        .cmd_wr_i         (w_cmd_wr),
        .cmd_rd_i         (w_cmd_rd),
        .cmd_addr_i       (w_cmd_addr),
        .cmd_wdata_i      (w_cmd_wdata),
        .xfer_done_o      (w_xfer_done),
        .av_address_o     (mgmt_address),
        .av_read_o        (mgmt_read),
        .av_write_o       (mgmt_write),
        .av_writedata_o   (mgmt_writedata),
        .av_waitrequest_i (mgmt_waitrequest)
    );

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign error     = error_q;

endmodule
`default_nettype wire
